// File: rtl/exp_align_pkg.sv
// Shared constants for the posit FMA exponent path.
// Mode encodings, lane geometry and the shift clamp helper.
package exp_align_pkg;

  localparam logic [1:0] MODE_Q4  = 2'b00;
  localparam logic [1:0] MODE_Q2  = 2'b01;
  localparam logic [1:0] MODE_Q1  = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  localparam int EXP_W     = 20;
  localparam int LANE_W_Q4 = 5;
  localparam int LANE_W_Q2 = 10;
  localparam int LANE_W_Q1 = 20;
  localparam int NUM_LANES = 4;
  localparam int SH_W      = 8;
  localparam int SHAMT_W   = NUM_LANES * SH_W;
  localparam int MAG_W     = LANE_W_Q1 + 1;

  function automatic logic [SH_W-1:0] sat_clamp(
    input logic [MAG_W-1:0] mag,
    input logic [SH_W-1:0]  sat
  );
    logic [SH_W-1:0] r;
    if (mag > {{(MAG_W-SH_W){1'b0}}, sat})
      r = sat;
    else
      r = mag[SH_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/exp_align_stage_cmp.sv
// Per-lane signed exponent compare/subtract.
// Emits the larger exponent, the swap flag and |E-F|.
module exp_lane_cmp #(
  parameter int W = 5
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] max_o,
  output logic         swap_o,
  output logic [W:0]   mag_o
);

  logic [W:0] d;

  // One extra bit keeps the difference exact.
  assign d      = {a_i[W-1], a_i} - {b_i[W-1], b_i};
  assign swap_o = d[W];
  assign max_o  = swap_o ? b_i : a_i;
  assign mag_o  = swap_o ? (~d + {{W{1'b0}}, 1'b1}) : d;

endmodule

// File: rtl/exp_align_stage.sv
// Two-deep valid/ready exponent alignment stage.
// s1 holds raw exponents, s2 holds max/swap/shamt.
module exp_align_stage
  import exp_align_pkg::*;
#(
  parameter int SAT_M0 = 8,
  parameter int SAT_M1 = 16,
  parameter int SAT_M2 = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  mode,
  input  logic [19:0] exp_E,
  input  logic [19:0] exp_F,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_mode,
  output logic [19:0] exp_max,
  output logic [3:0]  swap,
  output logic [31:0] shamt,
  output logic        illegal
);

  localparam logic [SH_W-1:0] SAT0 = SH_W'(SAT_M0);
  localparam logic [SH_W-1:0] SAT1 = SH_W'(SAT_M1);
  localparam logic [SH_W-1:0] SAT2 = SH_W'(SAT_M2);

  logic             s1_v_q;
  logic [1:0]       s1_mode_q;
  logic [EXP_W-1:0] s1_e_q;
  logic [EXP_W-1:0] s1_f_q;

  logic             s2_v_q;
  logic [1:0]       s2_mode_q;
  logic [EXP_W-1:0] s2_max_q;
  logic [3:0]       s2_swap_q;
  logic [31:0]      s2_sh_q;
  logic             s2_ill_q;

  logic [EXP_W-1:0] max_d;
  logic [3:0]       swap_d;
  logic [31:0]      sh_d;
  logic             ill_d;

  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  assign in_ready = s1_adv;

  logic [4:0]  m5 [4];
  logic [3:0]  sw5;
  logic [5:0]  g5 [4];
  logic [9:0]  m10 [2];
  logic [1:0]  sw10;
  logic [10:0] g10 [2];
  logic [19:0] m20;
  logic        sw20;
  logic [20:0] g20;

  for (genvar k = 0; k < 4; k++) begin : g_q4
    exp_lane_cmp #(.W(LANE_W_Q4)) u_cmp (
      .a_i    (s1_e_q[5*k +: 5]),
      .b_i    (s1_f_q[5*k +: 5]),
      .max_o  (m5[k]),
      .swap_o (sw5[k]),
      .mag_o  (g5[k])
    );
  end

  for (genvar k = 0; k < 2; k++) begin : g_q2
    exp_lane_cmp #(.W(LANE_W_Q2)) u_cmp (
      .a_i    (s1_e_q[10*k +: 10]),
      .b_i    (s1_f_q[10*k +: 10]),
      .max_o  (m10[k]),
      .swap_o (sw10[k]),
      .mag_o  (g10[k])
    );
  end

  exp_lane_cmp #(.W(LANE_W_Q1)) u_cmp_q1 (
    .a_i    (s1_e_q),
    .b_i    (s1_f_q),
    .max_o  (m20),
    .swap_o (sw20),
    .mag_o  (g20)
  );

  always_comb begin
    max_d  = '0;
    swap_d = '0;
    sh_d   = '0;
    ill_d  = 1'b0;
    unique case (1'b1)
      (s1_mode_q == MODE_Q4): begin
        for (int k = 0; k < 4; k++) begin
          max_d[5*k +: 5]  = m5[k];
          swap_d[k]        = sw5[k];
          sh_d[8*k +: 8]   = sat_clamp(MAG_W'(g5[k]), SAT0);
        end
      end
      (s1_mode_q == MODE_Q2): begin
        for (int k = 0; k < 2; k++) begin
          max_d[10*k +: 10] = m10[k];
          swap_d[k]         = sw10[k];
          sh_d[8*k +: 8]    = sat_clamp(MAG_W'(g10[k]), SAT1);
        end
      end
      (s1_mode_q == MODE_Q1): begin
        max_d     = m20;
        swap_d[0] = sw20;
        sh_d[7:0] = sat_clamp(g20, SAT2);
      end
      default: ill_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_mode_q <= '0;
      s1_e_q    <= '0;
      s1_f_q    <= '0;
    end else if (s1_adv) begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        s1_mode_q <= mode;
        s1_e_q    <= exp_E;
        s1_f_q    <= exp_F;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v_q    <= 1'b0;
      s2_mode_q <= '0;
      s2_max_q  <= '0;
      s2_swap_q <= '0;
      s2_sh_q   <= '0;
      s2_ill_q  <= 1'b0;
    end else if (s2_adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_mode_q <= s1_mode_q;
        s2_max_q  <= max_d;
        s2_swap_q <= swap_d;
        s2_sh_q   <= sh_d;
        s2_ill_q  <= ill_d;
      end
    end
  end

  assign out_valid = s2_v_q;
  assign out_mode  = s2_mode_q;
  assign exp_max   = s2_max_q;
  assign swap      = s2_swap_q;
  assign shamt     = s2_sh_q;
  assign illegal   = s2_ill_q;

endmodule

// File: tb/tb_exp_align_stage.sv
// Scoreboard bench for exp_align_stage.
// Expected beats queue on input handshake, compare at output.
module tb_exp_align_stage;

  localparam int SAT0 = 8;
  localparam int SAT1 = 16;
  localparam int SAT2 = 32;

  typedef struct packed {
    logic [1:0]  md;
    logic [19:0] mx;
    logic [3:0]  sw;
    logic [31:0] sh;
    logic        il;
  } exp_t;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [1:0]  mode = 0;
  logic [19:0] exp_E = 0;
  logic [19:0] exp_F = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [1:0]  out_mode;
  logic [19:0] exp_max;
  logic [3:0]  swap;
  logic [31:0] shamt;
  logic        illegal;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  exp_t cur_exp = '0;
  exp_t ex;

  exp_align_stage #(
    .SAT_M0(SAT0), .SAT_M1(SAT1), .SAT_M2(SAT2)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .exp_E(exp_E), .exp_F(exp_F),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .exp_max(exp_max),
    .swap(swap), .shamt(shamt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] m,
                                 input logic [19:0] e,
                                 input logic [19:0] f);
    exp_t r;
    int n, lanes, sat, mask, ev, fv, d, mag, mxi;
    r = '0;
    r.md = m;
    case (m)
      2'd0: begin n = 5;  lanes = 4; sat = SAT0; end
      2'd1: begin n = 10; lanes = 2; sat = SAT1; end
      2'd2: begin n = 20; lanes = 1; sat = SAT2; end
      default: begin n = 0; lanes = 0; sat = 0; r.il = 1'b1; end
    endcase
    mask = (1 << n) - 1;
    for (int k = 0; k < lanes; k++) begin
      ev = (int'(e) >> (n*k)) & mask;
      fv = (int'(f) >> (n*k)) & mask;
      if (ev >= (1 << (n-1))) ev -= (1 << n);
      if (fv >= (1 << (n-1))) fv -= (1 << n);
      d = ev - fv;
      if (d < 0) begin
        r.sw[k] = 1'b1;
        mxi = fv & mask;
        mag = -d;
      end else begin
        mxi = ev & mask;
        mag = d;
      end
      r.mx = r.mx | (20'(mxi) << (n*k));
      r.sh = r.sh | (32'((mag > sat) ? sat : mag) << (8*k));
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (q.size() == 0) begin
        check("no_stale_out", 32'(out_valid), 32'd0);
      end else if (out_valid) begin
        ex = q[0];
        check("out_mode", 32'(out_mode), 32'(ex.md));
        check("exp_max",  32'(exp_max),  32'(ex.mx));
        check("swap",     32'(swap),     32'(ex.sw));
        check("shamt",    shamt,         ex.sh);
        check("illegal",  32'(illegal),  32'(ex.il));
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(cur_exp);
    end
  end

  task automatic send(input logic [1:0] m,
                      input logic [19:0] e,
                      input logic [19:0] f,
                      input exp_t x);
    int n;
    logic acc;
    n = 0;
    in_valid = 1;
    mode     = m;
    exp_E    = e;
    exp_F    = f;
    cur_exp  = x;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send_m(input logic [1:0] m,
                        input logic [19:0] e,
                        input logic [19:0] f);
    send(m, e, f, model(m, e, f));
  endtask

  task automatic idle(input int c);
    in_valid = 0;
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_mode"},  32'(out_mode),  32'd0);
    check({tag, "_exp_max"},   32'(exp_max),   32'd0);
    check({tag, "_swap"},      32'(swap),      32'd0);
    check({tag, "_shamt"},     shamt,          32'd0);
    check({tag, "_illegal"},   32'(illegal),   32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;

    send(2'd0, 20'h00003, 20'h0001E,
         exp_t'{2'd0, 20'h00003, 4'h0, 32'h5, 1'b0});
    send(2'd2, 20'hFFF9C, 20'h000C8,
         exp_t'{2'd2, 20'h000C8, 4'h1, 32'd32, 1'b0});
    send(2'd1, 20'h01F00, 20'h01CFF,
         exp_t'{2'd1, 20'h01CFF, 4'h1, 32'h10, 1'b0});
    send(2'd3, 20'hABCDE, 20'h12345,
         exp_t'{2'd3, 20'h0, 4'h0, 32'h0, 1'b1});
    send(2'd0, 20'h8421F, 20'h0FFF0,
         model(2'd0, 20'h8421F, 20'h0FFF0));
    send_m(2'd0, {5'd8, 5'd0, 5'h0F, 5'h10},
                 {5'd0, 5'd8, 5'h10, 5'h0F});
    send_m(2'd1, {10'd16, 10'h200}, {10'd0, 10'h1FF});
    send_m(2'd2, 20'h7FFFF, 20'h80000);
    send_m(2'd2, 20'h00005, 20'h00005);
    drain();

    fork
      begin
        for (int i = 0; i < 6; i++)
          send_m(2'd0, 20'(i * 20'h1111), 20'(20'hFFFFF - i * 3));
        in_valid = 0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();

    send_m(2'd0, 20'h12345, 20'h54321);
    send_m(2'd1, 20'h0F0F0, 20'hF0F0F);
    in_valid = 0;
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_idle_outputs("midrst");
    idle(5);

    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send_m(2'($urandom_range(0, 3)),
                 20'($urandom()), 20'($urandom()));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        in_valid = 0;
      end
      begin
        repeat (80) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1;
      end
    join
    drain();
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exp_align_stage.md
# exp_align_stage

Pipelined exponent-alignment stage directly downstream of the lane-packed exponent adder in the posit FMA datapath. Each beat carries two product exponents (E = A·B, F = C·D) packed per precision mode. Per lane, the stage selects the larger exponent, flags which product is smaller, and produces a saturated right-shift amount for the smaller product's mantissa. The stage is a 2-deep valid/ready pipeline with full throughput and backpressure, feeding the mantissa aligner.

## Interface
- SAT_M0, default 8: shift saturation value, mode 00 (5-bit lanes).
- SAT_M1, default 16: shift saturation value, mode 01 (10-bit lanes).
- SAT_M2, default 32: shift saturation value, mode 10 (20-bit lane).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  input beat valid.
- in_ready  output  1  stage accepts a beat this cycle.
- mode  input  2  00 = 4×5-bit lanes, 01 = 2×10-bit lanes, 10 = 1×20-bit lane, 11 = reserved.
- exp_E  input  20  packed signed product exponents, lane k at bits [5k+4:5k] (m00), [10k+9:10k] (m01), or [19:0] (m10).
- exp_F  input  20  same packing as exp_E.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer accepts the beat.
- out_mode  output  2  mode of the output beat.
- exp_max  output  20  per-lane signed max(E, F), packed like the inputs.
- swap  output  4  bit k = 1 when F > E in lane k, so E is the shifted operand. Unused lanes are 0.
- shamt  output  32  lane k at [8k+7:8k], unsigned, equal to min(|E−F|, SAT_Mx). Unused lanes are 0.
- illegal  output  1  the output beat carried mode 11.

## Operation
- Lane count by mode: m00 = 4, m01 = 2, m10 = 1.
- Per lane of width n:
  - d = sext(E) − sext(F), computed at n+1 bits; never overflows.
  - When d ≥ 0: swap = 0, exp_max = E, shamt = min(d, SAT).
  - When d < 0: swap = 1, exp_max = F, shamt = min(−d, SAT).
  - When d = 0: swap = 0, shamt = 0.
- Clamp is to the mode's SAT parameter. SAT values are required to be ≤ 255.
- Mode 11: exp_max, swap and shamt are all 0 and illegal = 1. The beat still flows through the pipeline normally.
- Stage 1 registers the inputs and computes per-lane d and its sign.
- Stage 2 registers max, swap, the clamped magnitude, and mode.
- Each data register loads only when its stage advances. Data is held stable while out_valid && !out_ready.

## Timing
- Latency is 2 cycles from input handshake to out_valid. Throughput is 1 beat per cycle when out_ready is held high.
- s2 advances when !s2_valid || out_ready. s1 advances when !s1_valid || s2 advances. in_ready equals the s1 advance condition.
- in_ready is combinationally dependent on out_ready; no skid buffer.
- An input is accepted on in_valid && in_ready. An output is consumed on out_valid && out_ready.
- Stall: with out_ready = 0 and both stages full, in_ready = 0 and all outputs hold. Releasing out_ready drains one beat per cycle with no loss or duplication.
- Simultaneous accept and consume with both stages full: both occur in the same cycle.
- Reset:
  - Both stage valids clear to 0 and all data registers clear to 0.
  - After reset: out_valid = 0, out_mode = 0, exp_max = 0, swap = 0, shamt = 0, illegal = 0, in_ready = 1.
  - Reset asserted mid-stream discards in-flight beats. No out_valid is produced for them.

## Structure
- Shared package holds:
  - Mode encodings: MODE_Q4 = 2'b00, MODE_Q2 = 2'b01, MODE_Q1 = 2'b10, MODE_RSV = 2'b11.
  - Lane widths: 5, 10, 20.
  - Lane-field and shamt-field width constants, reused by the exponent adder and the mantissa aligner.
- Sub-module exp_lane_cmp, parameterised by lane width W:
  - Combinational signed compare and subtract; outputs max, swap and |d|.
  - Instantiated 4× at W=5, 2× at W=10 and 1× at W=20. Outputs are muxed by the registered mode.

## Test plan
- m00, E=20'h0_0003 (lane0 = 3), F=20'h0_001E (lane0 = −2), other lanes 0 → out 2 cycles later: lane0 exp_max=3, swap[0]=0, shamt[7:0]=5; lanes 1–3 exp_max=0, shamt=0.
- m10, E=−100, F=200, SAT_M2=32 → exp_max=20'd200, swap=4'b0001, shamt[7:0]=32 (saturated), illegal=0.
- m01, lane0 E=−256, F=255; lane1 E=F=7 → lane0 exp_max=255, swap[0]=1, shamt=16; lane1 exp_max=7, swap[1]=0, shamt=0.
- Backpressure: stream 6 beats with in_valid=1; hold out_ready=0 for cycles 2–5 → in_ready falls after 2 beats fill; outputs hold stable; all 6 beats emerge in order, exactly once.
- Mode 11 beat with arbitrary exponents → out_valid after 2 cycles with illegal=1 and exp_max/swap/shamt all 0; the following m00 beat is unaffected.
- Assert rst for 1 cycle while 2 beats are in flight → out_valid=0 the next cycle, all outputs 0, in_ready=1; no stale beat is emitted later.
